pkt_rx_ctrl: RTL and testbench

Receive-side sequencer for the 64-bit serial shift buffer. It generates the buffer's bit-shift enable at a fixed divided rate and hunts for the buffer's packet-received flag. On a hit it freezes the buffer and presents the captured frame on a valid/ready handshake, then issues the buffer's packet reset and re-arms. It sits between the serial front end and the packet consumer and owns every `en`/`pkt_rst` pulse the buffer sees.

---
 rtl/pkt_rx_ctrl_if.sv | 26 ++
 rtl/pkt_rx_ctrl.sv | 158 +++++++++++++++
 tb/tb_pkt_rx_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_rx_ctrl_if.sv
// Signal bundle between pkt_rx_ctrl, the serial shift buffer and the packet consumer.
// master: the sequencer side; slave: the buffer/consumer side.
interface pkt_rx_ctrl_if;
  logic        arm;
  logic        pkt_rec;
  logic [63:0] frame_in;
  logic        pkt_ready;
  logic        timeout_clr;
  logic        bit_en;
  logic        pkt_rst;
  logic [63:0] pkt_data;
  logic        pkt_valid;
  logic        timeout;
  logic [7:0]  pkt_count;
  logic        busy;

  modport master (
    input  arm, pkt_rec, frame_in, pkt_ready, timeout_clr,
    output bit_en, pkt_rst, pkt_data, pkt_valid, timeout, pkt_count, busy
  );

  modport slave (
    output arm, pkt_rec, frame_in, pkt_ready, timeout_clr,
    input  bit_en, pkt_rst, pkt_data, pkt_valid, timeout, pkt_count, busy
  );
endinterface

// File: rtl/pkt_rx_ctrl.sv
// Receive sequencer for the 64-bit serial shift buffer: divided shift enable, packet hunt, capture, handshake, re-arm.
// Define PKT_RX_TIMEOUT_EN to build the bit counter, sticky timeout flag and retry-on-timeout.
module pkt_rx_ctrl #(
  parameter int CLK_DIV      = 4,
  parameter int TIMEOUT_BITS = 128
) (
  input logic           clk,
  input logic           rst,
  pkt_rx_ctrl_if.master bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FLUSH   = 3'd1;
  localparam logic [2:0] S_HUNT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  if (CLK_DIV < 3) begin : g_chk_div
    $error("pkt_rx_ctrl: CLK_DIV must be at least 3");
  end
  if (TIMEOUT_BITS < 1 || TIMEOUT_BITS > 65535) begin : g_chk_to
    $error("pkt_rx_ctrl: TIMEOUT_BITS must be in 1..65535");
  end

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mask_q, mask_d;
  logic             bit_en_q, bit_en_d;
  logic             pkt_rst_q, pkt_rst_d;
  logic             valid_q, valid_d;
  logic [63:0]      data_q, data_d;
  logic [7:0]       count_q, count_d;
  logic             busy_q, busy_d;
  logic             hit;

`ifdef PKT_RX_TIMEOUT_EN
  localparam int BIT_W = $clog2(TIMEOUT_BITS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TIMEOUT_BITS);
  logic [BIT_W-1:0] bits_q, bits_d;
  logic             timeout_q, timeout_d;
  logic             expired;
  assign expired = (bits_q == BIT_LAST);
`endif

  // The buffer's flag still shows the previous frame for two cycles after a clear.
  assign hit = bus.pkt_rec && !mask_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
`ifdef PKT_RX_TIMEOUT_EN
    bits_d    = bits_q;
    timeout_d = bus.timeout_clr ? 1'b0 : timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.arm) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        div_d   = '0;
        mask_d  = 1'b1;
        state_d = S_HUNT;
`ifdef PKT_RX_TIMEOUT_EN
        bits_d  = '0;
`endif
      end
      S_HUNT: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (bit_en_q) begin
          mask_d = 1'b0;
`ifdef PKT_RX_TIMEOUT_EN
          if (!expired) bits_d = bits_q + 1'b1;
`endif
        end
        if (!bus.arm) state_d = S_IDLE;
        else if (hit) state_d = S_CAPTURE;
`ifdef PKT_RX_TIMEOUT_EN
        else if (expired) state_d = S_FLUSH;
        // Set has priority over a simultaneous clear.
        if (expired && !(bus.arm && hit)) timeout_d = 1'b1;
`endif
      end
      S_CAPTURE: begin
        data_d  = bus.frame_in;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (valid_q && bus.pkt_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 8'd1;
          state_d = bus.arm ? S_FLUSH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered outputs describe the state being entered.
    pkt_rst_d = (state_d == S_FLUSH);
    bit_en_d  = (state_q == S_HUNT) && (state_d == S_HUNT) && (div_q == DIV_PRE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      mask_q    <= 1'b0;
      bit_en_q  <= 1'b0;
      pkt_rst_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
`ifdef PKT_RX_TIMEOUT_EN
      bits_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      mask_q    <= mask_d;
      bit_en_q  <= bit_en_d;
      pkt_rst_q <= pkt_rst_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
`ifdef PKT_RX_TIMEOUT_EN
      bits_q    <= bits_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.bit_en    = bit_en_q;
  assign bus.pkt_rst   = pkt_rst_q;
  assign bus.pkt_data  = data_q;
  assign bus.pkt_valid = valid_q;
  assign bus.pkt_count = count_q;
  assign bus.busy      = busy_q;

`ifdef PKT_RX_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  logic unused_timeout_clr;
  assign unused_timeout_clr = bus.timeout_clr;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_rx_ctrl.sv
// Bench for pkt_rx_ctrl: behavioural shift buffer, directed phases, and a scoreboard checking every handshake.
module tb_pkt_rx_ctrl;
  localparam int CLK_DIV      = 4;
  localparam int TIMEOUT_BITS = 128;
  localparam logic [63:0] W   = 64'hA500_3FC0_0000_1234;

  localparam int W_VALID = 0;
  localparam int W_RST   = 1;
  localparam int W_BITS  = 2;
  localparam int W_CYC   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pkt_rx_ctrl_if bus ();

  pkt_rx_ctrl #(.CLK_DIV(CLK_DIV), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shift buffer: MSB-first stream, flag registered one cycle after the shift.
  logic [63:0] stream;
  logic [63:0] shreg;
  logic [6:0]  sidx;
  logic        din;
  logic        model_rec;
  logic        force_mode, force_rec;
  logic [63:0] force_frame;

  assign din = sidx[6] ? 1'b0 : stream[~sidx[5:0]];

  always @(posedge clk) begin
    if (rst || bus.pkt_rst) begin
      shreg <= '0;
      sidx  <= '0;
    end else if (bus.bit_en) begin
      shreg <= {shreg[62:0], din};
      sidx  <= sidx + 7'd1;
    end
    model_rec <= (shreg[45:38] == 8'hFF);
  end

  assign bus.pkt_rec  = force_mode ? force_rec : model_rec;
  assign bus.frame_in = force_mode ? force_frame : shreg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait budget expired, required event not seen", name);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bit_en"},    64'(bus.bit_en),    64'd0);
    check({tag, "_pkt_rst"},   64'(bus.pkt_rst),   64'd0);
    check({tag, "_pkt_valid"}, 64'(bus.pkt_valid), 64'd0);
    check({tag, "_timeout"},   64'(bus.timeout),   64'd0);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_pkt_data"},  bus.pkt_data,       64'd0);
    check({tag, "_pkt_count"}, 64'(bus.pkt_count), 64'd0);
  endtask

  // Scoreboard: stimulus pushes, the monitor pops on each handshake.
  typedef struct {
    logic [63:0] data;
    logic [7:0]  cnt;
  } exp_t;
  exp_t expq[$];

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.pkt_valid && bus.pkt_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got packet %0h, required none", bus.pkt_data);
        end else begin
          e = expq.pop_front();
          check("sb_data", bus.pkt_data, e.data);
          @(posedge clk);
          #1;
          check("sb_count", 64'(bus.pkt_count), 64'(e.cnt));
          $display("packet accepted: data=%h count=%0d", e.data, bus.pkt_count);
        end
      end
    end
  end

  // Walks negedges until the chosen event (or the budget), tallying pulses seen.
  int          t_bits, t_rst, t_valid, t_dchg, t_first_bit, t_last_bit;
  logic [63:0] hold_ref;

  task automatic step_until(input string name, input int what, input int budget, input int nbits);
    bit done = 1'b0;
    t_bits = 0; t_rst = 0; t_valid = 0; t_dchg = 0; t_first_bit = -1; t_last_bit = -1;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (bus.bit_en) begin
        t_bits++;
        if (t_first_bit < 0) t_first_bit = cyc;
        t_last_bit = cyc;
      end
      if (bus.pkt_rst) t_rst++;
      if (bus.pkt_valid) begin
        t_valid++;
        if (bus.pkt_data !== hold_ref) t_dchg++;
      end
      case (what)
        W_VALID: done = bus.pkt_valid;
        W_RST:   done = bus.pkt_rst;
        W_BITS:  done = (t_bits == nbits);
        default: done = 1'b0;
      endcase
    end
    if (what != W_CYC && !done) expire(name);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required self-finish");
    $fatal(1, "watchdog");
  end

  int a_cyc, r_cyc;

  initial begin : stimulus
    rst = 1'b1;
    bus.arm = 1'b0; bus.pkt_ready = 1'b0; bus.timeout_clr = 1'b0;
    force_mode = 1'b0; force_rec = 1'b0; force_frame = '0; stream = '0; hold_ref = W;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single packet through the real buffer, consumer always ready.
    stream = W; bus.pkt_ready = 1'b1;
    @(posedge clk); #1;
    bus.arm = 1'b1; a_cyc = cyc;
    expq.push_back('{W, 8'd1});
    step_until("flush1", W_RST, 5, 0);
    check("arm_to_rst", 64'(cyc - a_cyc), 64'd1);
    r_cyc = cyc;
    step_until("pkt1", W_VALID, 400, 0);
    check("pkt1_bits", 64'(t_bits), 64'd64);
    check("rst_to_bit", 64'(t_first_bit - r_cyc), 64'(CLK_DIV));
    check("bit_period", 64'(t_last_bit - t_first_bit), 64'(63 * CLK_DIV));
    check("bit_to_valid", 64'(cyc - t_last_bit), 64'd4);
    step_until("post1", W_CYC, 1, 0);
    check("valid_one_cycle", 64'(bus.pkt_valid), 64'd0);
    check("hs_to_rst", 64'(bus.pkt_rst), 64'd1);

    // Backpressure: second packet held for 20 cycles.
    @(posedge clk); #1;
    bus.pkt_ready = 1'b0;
    expq.push_back('{W, 8'd2});
    step_until("pkt2", W_VALID, 400, 0);
    check("pkt2_bits", 64'(t_bits), 64'd64);
    step_until("hold20", W_CYC, 20, 0);
    check("bp_bits", 64'(t_bits), 64'd0);
    check("bp_valid_cycles", 64'(t_valid), 64'd20);
    check("bp_data_changes", 64'(t_dchg), 64'd0);
    check("bp_rst", 64'(t_rst), 64'd0);
    @(posedge clk); #1;
    bus.pkt_ready = 1'b1; stream = '0;
    step_until("hs2", W_CYC, 1, 0);
    step_until("post2", W_CYC, 1, 0);
    check("post2_valid", 64'(bus.pkt_valid), 64'd0);
    check("post2_rst", 64'(bus.pkt_rst), 64'd1);

    // Abort after 10 bits.
    step_until("abort_bits", W_BITS, 100, 10);
    @(posedge clk); #1;
    bus.arm = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    step_until("abort_quiet", W_CYC, 20, 0);
    check("abort_rst", 64'(t_rst), 64'd0);
    check("abort_valid", 64'(t_valid), 64'd0);
    check("abort_bits_after", 64'(t_bits), 64'd0);

`ifdef PKT_RX_TIMEOUT_EN
    // Timeout, retry, clear, and set-over-clear priority.
    @(posedge clk); #1;
    bus.arm = 1'b1;
    step_until("to_flush", W_RST, 5, 0);
    step_until("to_bits", W_BITS, 600, TIMEOUT_BITS);
    check("to_at_last_bit", 64'(bus.timeout), 64'd0);
    step_until("to_gap", W_CYC, 1, 0);
    check("to_one_after", 64'(bus.timeout), 64'd0);
    step_until("to_set_cyc", W_CYC, 1, 0);
    check("to_set", 64'(bus.timeout), 64'd1);
    check("to_retry_rst", 64'(bus.pkt_rst), 64'd1);
    r_cyc = cyc;
    step_until("to_resume", W_BITS, 10, 1);
    check("to_resume_gap", 64'(t_first_bit - r_cyc), 64'(CLK_DIV));
    @(posedge clk); #1;
    bus.timeout_clr = 1'b1;
    @(posedge clk); #1;
    check("to_cleared", 64'(bus.timeout), 64'd0);
    step_until("to_second", W_RST, 700, 0);
    check("to_set_wins", 64'(bus.timeout), 64'd1);
    @(posedge clk); #1;
    bus.timeout_clr = 1'b0; bus.arm = 1'b0;
`else
    // Without the timeout build, hunting never gives up.
    @(posedge clk); #1;
    bus.arm = 1'b1; bus.timeout_clr = 1'b1;
    step_until("nt_flush", W_RST, 5, 0);
    step_until("nt_bits", W_BITS, 800, TIMEOUT_BITS + 10);
    check("nt_no_retry", 64'(t_rst), 64'd0);
    check("nt_timeout", 64'(bus.timeout), 64'd0);
    check("nt_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.timeout_clr = 1'b0; bus.arm = 1'b0;
`endif

    // Reset in the middle of HUNT.
    @(posedge clk); #1;
    bus.arm = 1'b1;
    step_until("rh_bits", W_BITS, 60, 5);
    @(posedge clk); #1;
    rst = 1'b1; bus.arm = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_hunt");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 256 quick packets with a forced flag: counter wraps to 0.
    force_mode = 1'b1; force_rec = 1'b1; bus.pkt_ready = 1'b1;
    @(posedge clk); #1;
    bus.arm = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      force_frame = {48'hC0DE_F00D_0000, 8'(i), ~8'(i)};
      hold_ref = force_frame;
      expq.push_back('{force_frame, 8'(i)});
      step_until("wrap_pkt", W_VALID, 40, 0);
      @(posedge clk); #1;
    end
    check("wrap_count", 64'(bus.pkt_count), 64'd0);

    // Reset while a packet is held drops it.
    bus.pkt_ready = 1'b0;
    force_frame = 64'h1111_2222_3333_4444;
    hold_ref = force_frame;
    step_until("hold_pkt", W_VALID, 40, 0);
    @(posedge clk); #1;
    rst = 1'b1; bus.arm = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_hold");
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (4) @(posedge clk);
    check("sb_empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
